// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte producers. In IDLE a winner
//   is chosen (round-robin by default), its byte is latched onto TX_data, it
//   gets a one-cycle req_ack, and TXstart is raised. The arbiter then waits for
//   the transmitter to report TXbusy and to finish the frame. After the frame,
//   it inserts GAP_CYCLES idle cycles before the next grant. If TXbusy never
//   rises within START_TIMEOUT cycles, the byte is dropped and tx_err pulses.
//
//   Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (the
//   lowest index wins and rr_ptr stays at 0). The default is round-robin.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   req[N_REQ]       request per producer, held until its req_ack
//   req_data         byte i at req_data[8*i+:8]
//   req_ack[N_REQ]   one-cycle pulse: byte of requester i latched
//   TXstart, TX_data to transmitter; TX_data stable from grant to frame end
//   TXbusy           from transmitter
//   grant_id         index of current/last granted requester
//   arb_busy         high in any state other than IDLE
//   tx_err           one-cycle pulse on start timeout
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic               TXstart,
  output logic [7:0]         TX_data,
  input  logic               TXbusy,
  output logic [2:0]         grant_id,
  output logic               arb_busy,
  output logic               tx_err
);

  localparam int PW       = $clog2(N_REQ);
  localparam int CNT_MAX  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int TO_LAST  = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [PW-1:0]    rr_ptr, rr_n;
  logic [N_REQ-1:0] ack_n;
  logic             txstart_n, err_n, arb_n;
  logic [7:0]       data_n;
  logic [2:0]       gid_n;

  logic             win_found;
  logic [PW-1:0]    win_idx, idx;
  logic [7:0]       win_byte;

  // Winner search: first set request starting at rr_ptr (or at 0 when fixed).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    win_byte  = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      idx = PW'(k);
`else
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
`endif
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (win_idx == PW'(i)) win_byte = req_data[8*i +: 8];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rr_n      = rr_ptr;
    ack_n     = '0;
    err_n     = 1'b0;
    txstart_n = TXstart;
    data_n    = TX_data;
    gid_n     = grant_id;
    case (state)
      IDLE: begin
        txstart_n = 1'b0;
        // A foreign frame (TXbusy already high) blocks new grants.
        if (win_found && !TXbusy) begin
          data_n         = win_byte;
          gid_n          = 3'(win_idx);
          ack_n[win_idx] = 1'b1;
          txstart_n      = 1'b1;
          cnt_n          = '0;
          state_n        = START;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
          rr_n = '0;
`else
          rr_n = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
`endif
        end
      end
      START: begin
        if (TXbusy) begin
          txstart_n = 1'b0;
          cnt_n     = '0;
          state_n   = BUSY;
        end else if (cnt == CW'(TO_LAST)) begin
          // Byte is dropped, not retried.
          txstart_n = 1'b0;
          err_n     = 1'b1;
          cnt_n     = '0;
          state_n   = GAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BUSY: begin
        txstart_n = 1'b0;
        if (!TXbusy) begin
          cnt_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        txstart_n = 1'b0;
        if (GAP_CYCLES == 0 || cnt == CW'(GAP_LAST)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        txstart_n = 1'b0;
        cnt_n     = '0;
        state_n   = IDLE;
      end
    endcase
    arb_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      req_ack  <= '0;
      TXstart  <= 1'b0;
      TX_data  <= 8'h00;
      grant_id <= 3'd0;
      arb_busy <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rr_ptr   <= rr_n;
      req_ack  <= ack_n;
      TXstart  <= txstart_n;
      TX_data  <= data_n;
      grant_id <= gid_n;
      arb_busy <= arb_n;
      tx_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural transmitter model plus a scoreboard
// of expected grants (id, byte) filled when requests are raised and drained on
// every req_ack.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 5;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           TXstart, TXbusy, arb_busy, tx_err;
  logic [7:0]     TX_data;
  logic [2:0]     grant_id;

  logic mdl_busy, busy_force, tx_alive;
  assign TXbusy = mdl_busy | busy_force;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(16), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .req_ack(req_ack), .TXstart(TXstart), .TX_data(TX_data), .TXbusy(TXbusy),
    .grant_id(grant_id), .arb_busy(arb_busy), .tx_err(tx_err));

  always #5 clock = ~clock;

  typedef struct { logic [2:0] id; logic [7:0] data; } exp_t;
  exp_t sbq[$];

  int        n_chk = 0, n_pass = 0, err_cnt = 0, mdl_ptr = 0;
  int        pending [N];
  logic [7:0] dat [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  // Transmitter model: accepts TXstart one cycle, busy for FRAME cycles.
  initial begin
    int fcnt;
    fcnt = 0;
    mdl_busy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n || !tx_alive) begin mdl_busy = 1'b0; fcnt = 0; end
      else if (fcnt > 0) begin fcnt--; if (fcnt == 0) mdl_busy = 1'b0; end
      else if (TXstart && !mdl_busy) begin mdl_busy = 1'b1; fcnt = FRAME; end
    end
  end

  initial forever begin
    @(negedge clock);
    if (tx_err === 1'b1) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  endtask

  // Independent grant-order model over the currently pending bytes.
  task automatic predict();
    int p [N];
    logic [7:0] d [N];
    int left, w;
    left = 0;
    for (int i = 0; i < N; i++) begin p[i] = pending[i]; d[i] = dat[i]; left += p[i]; end
    while (left > 0) begin
      w = -1;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (w < 0 && p[k] > 0) w = k;
`else
      for (int k = 0; k < N; k++) if (w < 0 && p[(mdl_ptr + k) % N] > 0) w = (mdl_ptr + k) % N;
`endif
      sbq.push_back('{3'(w), d[w]});
      d[w] = d[w] + 8'd1;
      p[w]--;
      left--;
      mdl_ptr = (w + 1) % N;
    end
  endtask

  task automatic raise(input int i, input logic [7:0] b, input int cnt);
    dat[i] = b; pending[i] = cnt; req[i] = 1'b1; drive_data();
  endtask

  // Called on a negedge with an ack visible: score it and update producers.
  task automatic check_ack();
    exp_t e;
    if (sbq.size() == 0) begin chk("ack_unexp", 32'(req_ack), 32'd0); return; end
    e = sbq.pop_front();
    chk("ack_vec", 32'(req_ack), 32'(1) << e.id);
    chk("tx_data", 32'(TX_data), 32'(e.data));
    chk("grant_id", 32'(grant_id), 32'(e.id));
    chk("txstart_on_ack", 32'(TXstart), 32'd1);
    for (int i = 0; i < N; i++)
      if (req_ack[i]) begin
        pending[i]--;
        if (pending[i] <= 0) begin pending[i] = 0; req[i] = 1'b0; end
        else begin dat[i] = dat[i] + 8'd1; drive_data(); end
      end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got, cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clock); cyc++;
      if (|req_ack) begin got++; check_ack(); end
    end
    if (got < n) chk("ack_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_busy_phase();
    int cyc;
    cyc = 0;
    while (!(TXbusy && !TXstart) && cyc < 100) begin @(negedge clock); cyc++; end
    if (cyc >= 100) chk("busy_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    int k, cyc, seen;
    tx_alive = 1'b1; busy_force = 1'b0;
    req = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin pending[i] = 0; dat[i] = 8'h00; end

    // 1. reset with every request high
    reset_n = 1'b0;
    raise(0, 8'h01, 1); raise(1, 8'h11, 1); raise(2, 8'h21, 1); raise(3, 8'h31, 1);
    repeat (3) @(negedge clock);
    chk("rst_txstart", 32'(TXstart), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_tx_data", 32'(TX_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    mdl_ptr = 0;
    predict();
    reset_n = 1'b1;
    wait_acks(4, 400);

    // 2. single request, then measure gap before the next grant
    raise(2, 8'hB3, 1);
    predict();
    wait_acks(1, 100);
    raise(0, 8'h5A, 1);
    predict();
    cyc = 0;
    while (TXbusy && cyc < 100) begin @(negedge clock); cyc++; end
    if (cyc >= 100) chk("frame_end_timeout", 32'(cyc), 32'd0);
    k = 0;
    while (!(|req_ack) && k < 100) begin @(negedge clock); k++; end
    chk("gap_latency", 32'(k), 32'd4);
    if (|req_ack) check_ack();

    // 3. round-robin from a fresh pointer, requester 0 holds for two bytes
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1; mdl_ptr = 0;
    raise(0, 8'h40, 2); raise(1, 8'h50, 1); raise(2, 8'h60, 1); raise(3, 8'h70, 1);
    predict();
    wait_acks(5, 600);

    // 4. start timeout with a dead transmitter
    tx_alive = 1'b0;
    raise(1, 8'hC7, 1);
    predict();
    wait_acks(1, 100);
    k = 0;
    while (TXstart === 1'b1 && k < 100) begin k++; @(negedge clock); end
    chk("timeout_len", 32'(k), 32'd16);
    chk("tx_err_pulse", 32'(tx_err), 32'd1);
    @(negedge clock);
    chk("tx_err_once", 32'(tx_err), 32'd0);
    tx_alive = 1'b1;
    raise(3, 8'hE1, 1);
    predict();
    wait_acks(1, 100);

    // 5. reset in BUSY
    raise(0, 8'h77, 1);
    predict();
    wait_acks(1, 100);
    wait_busy_phase();
    reset_n = 1'b0;
    #1;
    chk("midrst_txstart", 32'(TXstart), 32'd0);
    chk("midrst_arb_busy", 32'(arb_busy), 32'd0);
    @(negedge clock); reset_n = 1'b1; mdl_ptr = 0;
    raise(1, 8'h3C, 1);
    predict();
    wait_acks(1, 100);

    // 6. requester 3 withdraws while requester 2's frame is in BUSY
    raise(2, 8'h99, 1);
    sbq.push_back('{3'd2, 8'h99});
    raise(3, 8'hAA, 1);
    wait_acks(1, 100);
    wait_busy_phase();
    req[3] = 1'b0; pending[3] = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (|req_ack) begin seen++; check_ack(); end
    end
    chk("withdraw_acks", 32'(seen), 32'd0);
    chk("end_arb_busy", 32'(arb_busy), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("err_total", 32'(err_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
